// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: ALU state codes, keypad
// codes, stored-operation encoding and small decode helpers.
package calc_pkg;

    // ALU state codes; the ALU decodes these directly
    localparam logic [5:0] CODE_START      = 6'd0;
    localparam logic [5:0] CODE_SET_A      = 6'd1;
    localparam logic [5:0] CODE_SET_A_TEN  = 6'd2;
    localparam logic [5:0] CODE_SET_A_HUN  = 6'd3;
    localparam logic [5:0] CODE_SET_A_THUN = 6'd4;
    localparam logic [5:0] CODE_SET_B      = 6'd5;
    localparam logic [5:0] CODE_SET_B_TEN  = 6'd6;
    localparam logic [5:0] CODE_SET_B_HUN  = 6'd7;
    localparam logic [5:0] CODE_SET_B_THUN = 6'd8;
    localparam logic [5:0] CODE_ADD        = 6'd9;
    localparam logic [5:0] CODE_SUB        = 6'd10;
    localparam logic [5:0] CODE_SUM        = 6'd11;
    localparam logic [5:0] CODE_MUL        = 6'd12;
    localparam logic [5:0] CODE_ALU        = 6'd13;

    typedef enum logic [5:0] {
        S_START      = CODE_START,
        S_SET_A      = CODE_SET_A,
        S_SET_A_TEN  = CODE_SET_A_TEN,
        S_SET_A_HUN  = CODE_SET_A_HUN,
        S_SET_A_THUN = CODE_SET_A_THUN,
        S_SET_B      = CODE_SET_B,
        S_SET_B_TEN  = CODE_SET_B_TEN,
        S_SET_B_HUN  = CODE_SET_B_HUN,
        S_SET_B_THUN = CODE_SET_B_THUN,
        S_ADD        = CODE_ADD,
        S_SUB        = CODE_SUB,
        S_SUM        = CODE_SUM,
        S_MUL        = CODE_MUL,
        S_ALU        = CODE_ALU
    } state_e;

    // Keypad codes; 0..9 are digits, 15..31 are ignored
    localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;
    localparam logic [4:0] KEY_ADD       = 5'd10;
    localparam logic [4:0] KEY_SUB       = 5'd11;
    localparam logic [4:0] KEY_MUL       = 5'd12;
    localparam logic [4:0] KEY_EQ        = 5'd13;
    localparam logic [4:0] KEY_CLR       = 5'd14;

    // Stored operation
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    function automatic logic key_is_digit(input logic [4:0] code);
        return (code <= KEY_DIGIT_MAX);
    endfunction

    function automatic logic key_is_op(input logic [4:0] code);
        return (code == KEY_ADD) || (code == KEY_SUB) || (code == KEY_MUL);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [4:0] code);
        logic [1:0] op;
        case (code)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    // Next digit-entry state; the thousands state is terminal
    function automatic state_e next_entry_state(input state_e cur);
        state_e nxt;
        case (cur)
            S_SET_A:     nxt = S_SET_A_TEN;
            S_SET_A_TEN: nxt = S_SET_A_HUN;
            S_SET_A_HUN: nxt = S_SET_A_THUN;
            S_SET_B:     nxt = S_SET_B_TEN;
            S_SET_B_TEN: nxt = S_SET_B_HUN;
            S_SET_B_HUN: nxt = S_SET_B_THUN;
            default:     nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Saturating decimal operand accumulator: value <= min(value*10 + d, 2^W-1).
// Accepts four digits; a 2-bit counter plus a full flag stop further entry.
// clr restarts from zero (combinable with a digit in the same cycle);
// load overwrites the value with an arbitrary operand and restarts the count.
module calc_digit_acc
    import calc_pkg::*;
#(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         clr,
    input  logic         digit_vld,
    input  logic [3:0]   digit,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] val,
    output logic         full
);

    localparam logic [W+3:0] TEN_C = {{W{1'b0}}, 4'd10};
    localparam logic [W+3:0] SAT_C = {4'b0000, {W{1'b1}}};

    logic [W-1:0] val_q, val_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         full_q, full_d;
    logic [W-1:0] base_val_s;
    logic [1:0]   base_cnt_s;
    logic         base_full_s;
    logic [W+3:0] acc_s;

    // Next value: optional clear, then one saturating x10+d step or a load
    always_comb begin
        if (clr) begin
            base_val_s  = {W{1'b0}};
            base_cnt_s  = 2'd0;
            base_full_s = 1'b0;
        end else begin
            base_val_s  = val_q;
            base_cnt_s  = cnt_q;
            base_full_s = full_q;
        end
        acc_s  = ({4'b0000, base_val_s} * TEN_C) + {{W{1'b0}}, digit};
        val_d  = base_val_s;
        cnt_d  = base_cnt_s;
        full_d = base_full_s;
        if (load) begin
            val_d  = load_val;
            cnt_d  = 2'd0;
            full_d = 1'b0;
        end else if (digit_vld && !base_full_s) begin
            if (acc_s > SAT_C) begin
                val_d = {W{1'b1}};
            end else begin
                val_d = acc_s[W-1:0];
            end
            if (base_cnt_s == 2'd3) begin
                full_d = 1'b1;
            end else begin
                cnt_d = base_cnt_s + 2'd1;
            end
        end else begin
            val_d = base_val_s;
        end
    end

    // Accumulator registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            val_q  <= {W{1'b0}};
            cnt_q  <= 2'd0;
            full_q <= 1'b0;
        end else begin
            val_q  <= val_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign val  = val_q;
    assign full = full_q;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencer: builds operands A/B from keypad digits, steps the ALU
// through its state codes and captures the result as magnitude plus sign.
// Optional feature macro AUTO_CLEAR_EN: return to START after TIMEOUT_CYC
// idle cycles spent outside START/SET_A.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int W           = 13,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         key_vld,
    input  logic [4:0]   key_code,
    input  logic [W-1:0] sum_add,
    input  logic [W-1:0] sum_sub,
    input  logic [W-1:0] sum_mul,
    input  logic [W-1:0] sum_neg,
    output logic [5:0]   state,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic [W-1:0] result,
    output logic         result_neg,
    output logic         result_ovf,
    output logic         result_vld,
    output logic         busy
);

    state_e       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [W-1:0] result_q, result_d;
    logic         result_neg_q, result_neg_d;
    logic         result_ovf_q, result_ovf_d;
    logic         result_vld_q, result_vld_d;
    logic         busy_q, busy_d;

    logic         a_clr_s, a_dig_s, a_load_s, a_full_s;
    logic [W-1:0] a_load_val_s, a_val_s;
    logic         b_clr_s, b_dig_s, b_full_s;
    logic [W-1:0] b_val_s;
    logic [W:0]   add_wide_s;
    logic         timeout_s;

    assign add_wide_s = {1'b0, a_val_s} + {1'b0, b_val_s};

`ifdef AUTO_CLEAR_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    // Idle counter: runs outside START/SET_A while no key arrives
    always_comb begin
        timeout_s = 1'b0;
        if (key_vld || (state_q == S_START) || (state_q == S_SET_A)) begin
            idle_cnt_d = {CNT_W{1'b0}};
        end else if (idle_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            idle_cnt_d = {CNT_W{1'b0}};
            timeout_s  = 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
    end

    // Idle counter register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            idle_cnt_q <= {CNT_W{1'b0}};
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, operand control and result capture
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        result_d     = result_q;
        result_neg_d = result_neg_q;
        result_ovf_d = result_ovf_q;
        result_vld_d = result_vld_q;
        a_clr_s      = 1'b0;
        a_dig_s      = 1'b0;
        a_load_s     = 1'b0;
        a_load_val_s = {W{1'b0}};
        b_clr_s      = 1'b0;
        b_dig_s      = 1'b0;

        case (state_q)
            S_START: begin
                state_d = S_SET_A;
            end
            S_SET_A, S_SET_A_TEN, S_SET_A_HUN, S_SET_A_THUN: begin
                if (!key_vld) begin
                    state_d = state_q;
                end else if (key_code == KEY_CLR) begin
                    state_d = S_START;
                end else if (key_is_digit(key_code)) begin
                    if (!a_full_s) begin
                        a_dig_s = 1'b1;
                        state_d = next_entry_state(state_q);
                    end else begin
                        state_d = state_q;
                    end
                end else if (key_is_op(key_code)) begin
                    op_d    = key_to_op(key_code);
                    b_clr_s = 1'b1;
                    state_d = S_SET_B;
                end else begin
                    state_d = state_q;
                end
            end
            S_SET_B, S_SET_B_TEN, S_SET_B_HUN, S_SET_B_THUN: begin
                if (!key_vld) begin
                    state_d = state_q;
                end else if (key_code == KEY_CLR) begin
                    state_d = S_START;
                end else if (key_is_digit(key_code)) begin
                    if (!b_full_s) begin
                        b_dig_s = 1'b1;
                        state_d = next_entry_state(state_q);
                    end else begin
                        state_d = state_q;
                    end
                end else if (key_is_op(key_code)) begin
                    op_d = key_to_op(key_code);
                end else if (key_code == KEY_EQ) begin
                    case (op_q)
                        OP_SUB:  state_d = S_SUB;
                        OP_MUL:  state_d = S_MUL;
                        default: state_d = S_ADD;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            S_ADD, S_MUL, S_SUM: begin
                state_d = S_ALU;
            end
            S_SUB: begin
                state_d = S_SUM;
            end
            S_ALU: begin
                if (!result_vld_q) begin
                    result_vld_d = 1'b1;
                    case (op_q)
                        OP_SUB: begin
                            result_neg_d = (a_val_s < b_val_s);
                            result_d     = (a_val_s < b_val_s) ? sum_neg : sum_sub;
                            result_ovf_d = 1'b0;
                        end
                        OP_MUL: begin
                            result_neg_d = 1'b0;
                            result_d     = sum_mul;
                            result_ovf_d = 1'b0;
                        end
                        default: begin
                            result_neg_d = 1'b0;
                            result_d     = sum_add;
                            result_ovf_d = add_wide_s[W];
                        end
                    endcase
                end else begin
                    result_vld_d = 1'b1;
                end
                if (!key_vld) begin
                    state_d = state_q;
                end else if (key_code == KEY_CLR) begin
                    state_d = S_START;
                end else if (key_is_digit(key_code)) begin
                    a_clr_s = 1'b1;
                    a_dig_s = 1'b1;
                    state_d = S_SET_A_TEN;
                end else if (key_is_op(key_code)) begin
                    // Chaining: the raw (unsigned) ALU output becomes A
                    a_load_s = 1'b1;
                    case (op_q)
                        OP_SUB:  a_load_val_s = sum_sub;
                        OP_MUL:  a_load_val_s = sum_mul;
                        default: a_load_val_s = sum_add;
                    endcase
                    op_d    = key_to_op(key_code);
                    b_clr_s = 1'b1;
                    state_d = S_SET_B;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_START;
            end
        endcase

        if (timeout_s) begin
            state_d = S_START;
        end else begin
            state_d = state_d;
        end

        // Entering or sitting in START leaves operands and op cleared
        if (state_d == S_START) begin
            a_clr_s  = 1'b1;
            a_dig_s  = 1'b0;
            a_load_s = 1'b0;
            b_clr_s  = 1'b1;
            b_dig_s  = 1'b0;
            op_d     = OP_ADD;
        end else begin
            op_d = op_d;
        end

        // result_vld lives only while in the ALU state
        if (state_d != S_ALU) begin
            result_vld_d = 1'b0;
        end else begin
            result_vld_d = result_vld_d;
        end

        busy_d = (state_d == S_ADD) || (state_d == S_SUB) ||
                 (state_d == S_SUM) || (state_d == S_MUL);
    end

    // Controller registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= S_START;
            op_q         <= OP_ADD;
            result_q     <= {W{1'b0}};
            result_neg_q <= 1'b0;
            result_ovf_q <= 1'b0;
            result_vld_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            result_q     <= result_d;
            result_neg_q <= result_neg_d;
            result_ovf_q <= result_ovf_d;
            result_vld_q <= result_vld_d;
            busy_q       <= busy_d;
        end
    end

    calc_digit_acc #(.W(W)) u_acc_a (
        .clk       (clk),
        .clr_n     (clr_n),
        .clr       (a_clr_s),
        .digit_vld (a_dig_s),
        .digit     (key_code[3:0]),
        .load      (a_load_s),
        .load_val  (a_load_val_s),
        .val       (a_val_s),
        .full      (a_full_s)
    );

    calc_digit_acc #(.W(W)) u_acc_b (
        .clk       (clk),
        .clr_n     (clr_n),
        .clr       (b_clr_s),
        .digit_vld (b_dig_s),
        .digit     (key_code[3:0]),
        .load      (1'b0),
        .load_val  ({W{1'b0}}),
        .val       (b_val_s),
        .full      (b_full_s)
    );

    assign state      = state_q;
    assign A          = a_val_s;
    assign B          = b_val_s;
    assign result     = result_q;
    assign result_neg = result_neg_q;
    assign result_ovf = result_ovf_q;
    assign result_vld = result_vld_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed self-checking bench for calc_ctrl with a behavioural ALU model.
module tb_calc_ctrl;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        key_vld;
    logic [4:0]  key_code;
    logic [12:0] sum_add, sum_sub, sum_mul, sum_neg;
    logic [5:0]  state;
    logic [12:0] A, B, result;
    logic        result_neg, result_ovf, result_vld, busy;

    int checks = 0;
    int errors = 0;

    calc_ctrl #(.W(13), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .clr_n(clr_n), .key_vld(key_vld), .key_code(key_code),
        .sum_add(sum_add), .sum_sub(sum_sub), .sum_mul(sum_mul), .sum_neg(sum_neg),
        .state(state), .A(A), .B(B), .result(result), .result_neg(result_neg),
        .result_ovf(result_ovf), .result_vld(result_vld), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 13-bit wrap-around arithmetic on the operands
    always_comb begin
        sum_add = A + B;
        sum_sub = A - B;
        sum_mul = A * B;
        sum_neg = 13'd0 - (A - B);
    end

    // Called at a negedge: strobe one key for exactly one rising edge
    task automatic press(input logic [4:0] code);
        key_code = code;
        key_vld  = 1'b1;
        @(negedge clk);
        key_vld  = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; key_vld = 1'b0; key_code = 5'd0;
        repeat (3) @(negedge clk);
        checks++; if (state !== 6'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (A !== 13'd0 || B !== 13'd0 || result !== 13'd0) begin errors++; $display("FAIL reset_operands: got A=%0d B=%0d result=%0d expected 0", A, B, result); end
        checks++; if ({result_neg, result_ovf, result_vld, busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {result_neg, result_ovf, result_vld, busy}); end
        clr_n = 1'b1;
        @(negedge clk);
        checks++; if (state !== 6'd1) begin errors++; $display("FAIL start_to_set_a: got %0d expected 1", state); end
    endtask

    task automatic test_add();
        press(5'd1);
        checks++; if (state !== 6'd2 || A !== 13'd1) begin errors++; $display("FAIL add_digit1: got state=%0d A=%0d expected 2/1", state, A); end
        press(5'd2);
        checks++; if (state !== 6'd3 || A !== 13'd12) begin errors++; $display("FAIL add_digit2: got state=%0d A=%0d expected 3/12", state, A); end
        press(5'd10); press(5'd3); press(5'd4);
        checks++; if (state !== 6'd7 || B !== 13'd34) begin errors++; $display("FAIL add_operand_b: got state=%0d B=%0d expected 7/34", state, B); end
        press(5'd13);
        checks++; if (state !== 6'd9 || busy !== 1'b1) begin errors++; $display("FAIL add_state_add: got state=%0d busy=%0d expected 9/1", state, busy); end
        @(negedge clk);
        checks++; if (state !== 6'd13 || result_vld !== 1'b0) begin errors++; $display("FAIL add_state_alu: got state=%0d vld=%0d expected 13/0", state, result_vld); end
        @(negedge clk);
        checks++; if (result_vld !== 1'b1 || result !== 13'd46 || result_neg !== 1'b0 || result_ovf !== 1'b0) begin errors++; $display("FAIL add_result: got vld=%0d res=%0d neg=%0d ovf=%0d expected 1/46/0/0", result_vld, result, result_neg, result_ovf); end
        @(negedge clk);
        checks++; if (result_vld !== 1'b1) begin errors++; $display("FAIL add_vld_hold: got %0d expected 1", result_vld); end
    endtask

    task automatic test_sub();
        press(5'd14);
        checks++; if (state !== 6'd0 || result_vld !== 1'b0 || A !== 13'd0) begin errors++; $display("FAIL clr_from_alu: got state=%0d vld=%0d A=%0d expected 0/0/0", state, result_vld, A); end
        @(negedge clk);
        press(5'd5); press(5'd11); press(5'd9); press(5'd13);
        checks++; if (state !== 6'd10) begin errors++; $display("FAIL sub_state_sub: got %0d expected 10", state); end
        @(negedge clk);
        checks++; if (state !== 6'd11 || busy !== 1'b1) begin errors++; $display("FAIL sub_state_sum: got state=%0d busy=%0d expected 11/1", state, busy); end
        @(negedge clk);
        checks++; if (state !== 6'd13 || result_vld !== 1'b0) begin errors++; $display("FAIL sub_state_alu: got state=%0d vld=%0d expected 13/0", state, result_vld); end
        @(negedge clk);
        checks++; if (result_vld !== 1'b1 || result !== 13'd4 || result_neg !== 1'b1) begin errors++; $display("FAIL sub_neg_result: got vld=%0d res=%0d neg=%0d expected 1/4/1", result_vld, result, result_neg); end
        press(5'd14); @(negedge clk);
        press(5'd9); press(5'd11); press(5'd5); press(5'd13);
        repeat (3) @(negedge clk);
        checks++; if (result_vld !== 1'b1 || result !== 13'd4 || result_neg !== 1'b0) begin errors++; $display("FAIL sub_pos_result: got vld=%0d res=%0d neg=%0d expected 1/4/0", result_vld, result, result_neg); end
    endtask

    task automatic test_mul_chain();
        press(5'd14); @(negedge clk);
        press(5'd1); press(5'd2); press(5'd3); press(5'd12); press(5'd4); press(5'd5);
        checks++; if (A !== 13'd123 || B !== 13'd45) begin errors++; $display("FAIL mul_operands: got A=%0d B=%0d expected 123/45", A, B); end
        press(5'd13);
        checks++; if (state !== 6'd12) begin errors++; $display("FAIL mul_state: got %0d expected 12", state); end
        repeat (2) @(negedge clk);
        checks++; if (result_vld !== 1'b1 || result !== 13'd5535 || result_ovf !== 1'b0) begin errors++; $display("FAIL mul_result: got vld=%0d res=%0d ovf=%0d expected 1/5535/0", result_vld, result, result_ovf); end
        press(5'd12);
        checks++; if (state !== 6'd5 || A !== 13'd5535 || B !== 13'd0 || result_vld !== 1'b0) begin errors++; $display("FAIL chain_load: got state=%0d A=%0d B=%0d vld=%0d expected 5/5535/0/0", state, A, B, result_vld); end
        press(5'd2); press(5'd13);
        repeat (2) @(negedge clk);
        checks++; if (result_vld !== 1'b1 || result !== 13'd2878 || result_ovf !== 1'b0) begin errors++; $display("FAIL chain_mul_result: got vld=%0d res=%0d ovf=%0d expected 1/2878/0", result_vld, result, result_ovf); end
    endtask

    task automatic test_ignored_keys();
        press(5'd14); @(negedge clk);
        press(5'd13);
        checks++; if (state !== 6'd1) begin errors++; $display("FAIL eq_in_set_a: got %0d expected 1", state); end
        press(5'd20);
        checks++; if (state !== 6'd1 || A !== 13'd0) begin errors++; $display("FAIL undefined_key: got state=%0d A=%0d expected 1/0", state, A); end
    endtask

    task automatic test_saturate();
        press(5'd9); press(5'd9); press(5'd9);
        checks++; if (state !== 6'd4 || A !== 13'd999) begin errors++; $display("FAIL sat_three_digits: got state=%0d A=%0d expected 4/999", state, A); end
        press(5'd9);
        checks++; if (state !== 6'd4 || A !== 13'd8191) begin errors++; $display("FAIL sat_fourth_digit: got state=%0d A=%0d expected 4/8191", state, A); end
        press(5'd9);
        checks++; if (state !== 6'd4 || A !== 13'd8191) begin errors++; $display("FAIL sat_fifth_ignored: got state=%0d A=%0d expected 4/8191", state, A); end
        press(5'd10); press(5'd1); press(5'd13);
        repeat (2) @(negedge clk);
        checks++; if (result_vld !== 1'b1 || result !== 13'd0 || result_ovf !== 1'b1) begin errors++; $display("FAIL add_overflow: got vld=%0d res=%0d ovf=%0d expected 1/0/1", result_vld, result, result_ovf); end
    endtask

    task automatic test_busy_and_reset();
        press(5'd14); @(negedge clk);
        press(5'd7);
        press(5'd14);
        checks++; if (state !== 6'd0 || A !== 13'd0) begin errors++; $display("FAIL clr_mid_entry: got state=%0d A=%0d expected 0/0", state, A); end
        @(negedge clk);
        press(5'd3); press(5'd11); press(5'd1); press(5'd13);
        press(5'd14);
        checks++; if (state !== 6'd11 || A !== 13'd3 || busy !== 1'b1) begin errors++; $display("FAIL clr_while_busy: got state=%0d A=%0d busy=%0d expected 11/3/1", state, A, busy); end
        clr_n = 1'b0;
        #1;
        checks++; if (state !== 6'd0 || A !== 13'd0 || B !== 13'd0 || result !== 13'd0) begin errors++; $display("FAIL async_reset_values: got state=%0d A=%0d B=%0d res=%0d expected 0", state, A, B, result); end
        checks++; if ({result_neg, result_ovf, result_vld, busy} !== 4'b0000) begin errors++; $display("FAIL async_reset_flags: got %b expected 0000", {result_neg, result_ovf, result_vld, busy}); end
        #1;
        clr_n = 1'b1;
        @(negedge clk);
        checks++; if (state !== 6'd1) begin errors++; $display("FAIL after_reset_state: got %0d expected 1", state); end
    endtask

`ifdef AUTO_CLEAR_EN
    task automatic test_auto_clear();
        press(5'd4);
        repeat (15) @(negedge clk);
        checks++; if (state !== 6'd2 || A !== 13'd4) begin errors++; $display("FAIL idle_before_timeout: got state=%0d A=%0d expected 2/4", state, A); end
        @(negedge clk);
        checks++; if (state !== 6'd0 || A !== 13'd0) begin errors++; $display("FAIL idle_timeout: got state=%0d A=%0d expected 0/0", state, A); end
        @(negedge clk);
        press(5'd4);
        repeat (14) @(negedge clk);
        press(5'd5);
        checks++; if (state !== 6'd3 || A !== 13'd45) begin errors++; $display("FAIL idle_key_restart: got state=%0d A=%0d expected 3/45", state, A); end
        repeat (15) @(negedge clk);
        checks++; if (state !== 6'd3) begin errors++; $display("FAIL idle_restarted_count: got %0d expected 3", state); end
        @(negedge clk);
        checks++; if (state !== 6'd0 || A !== 13'd0) begin errors++; $display("FAIL idle_second_timeout: got state=%0d A=%0d expected 0/0", state, A); end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul_chain();
        test_ignored_keys();
        test_saturate();
        test_busy_and_reset();
`ifdef AUTO_CLEAR_EN
        test_auto_clear();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
